input_debouncer: RTL

- Multi-channel debouncer between the board push-button pins and the MCU `buttons_async` inputs.
- Synchronizes raw bouncing contacts and filters them with a shared sample prescaler plus a per-channel stability counter.
- Drives clean levels into the MCU, and optionally one-cycle edge pulses.
- Removes contact bounce that the MCU's plain 2-FF synchronizers pass through.

---
 rtl/input_debouncer_pkg.sv | 27 ++
 rtl/input_debouncer_channel.sv | 120 ++++++++++++
 rtl/input_debouncer.sv | 61 ++++++
 3 files changed

// File: rtl/input_debouncer_pkg.sv
// ---------------------------------------------------------------------------
// input_debouncer_pkg
// Shared types and sizing helpers for the push-button debouncer.
// Optional feature macro used by this block: INPUT_DEBOUNCER_EDGE_EN
// ---------------------------------------------------------------------------
package input_debouncer_pkg;

    // Per-channel filter state: STABLE holds the accepted level, PENDING is
    // counting consecutive samples that disagree with it.
    typedef enum logic {
        DB_STABLE,
        DB_PENDING
    } debounce_state_t;

    // Width of the stability counter; it must be able to hold STABLE_SAMPLES-1
    // and is sized from STABLE_SAMPLES+1 so a value of 1 still yields 1 bit.
    function automatic int cnt_width(input int stable_samples);
        return (stable_samples < 1) ? 1 : $clog2(stable_samples + 1);
    endfunction

    // Width of the shared prescaler counting 0..SAMPLE_PERIOD-1. A period of
    // one still gets a single (constant zero) bit so the compare stays legal.
    function automatic int presc_width(input int sample_period);
        return (sample_period <= 1) ? 1 : $clog2(sample_period);
    endfunction

endpackage : input_debouncer_pkg

// File: rtl/input_debouncer_channel.sv
// ---------------------------------------------------------------------------
// debounce_channel
// One debouncer lane: 2-FF synchronizer, STABLE/PENDING filter FSM with a
// stability counter, and optional registered edge pulses.
// Edge pulses are generated only when INPUT_DEBOUNCER_EDGE_EN is defined;
// otherwise o_rise/o_fall are tied low and the level path is unchanged.
// ---------------------------------------------------------------------------
module debounce_channel
    import input_debouncer_pkg::*;
#(
    parameter int   STABLE_SAMPLES = 8,
    parameter logic RESET_LEVEL    = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_tick,
    input  logic i_raw,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    localparam int CW = cnt_width(STABLE_SAMPLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_SAMPLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam bit SINGLE_SAMPLE = (STABLE_SAMPLES == 1);

    logic            r_sync1;
    logic            r_sync2;
    debounce_state_t r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_level;

    logic w_differs;
    logic w_flip;

    // Two-flop synchronizer; the reset value matches the debounced level so
    // leaving reset never looks like a pending change.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= RESET_LEVEL;
            r_sync2 <= RESET_LEVEL;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
        end
    end

    // The accepted level toggles on the tick that completes the run of
    // STABLE_SAMPLES disagreeing samples (or on the first one when a single
    // sample is enough).
    assign w_differs = (r_sync2 != r_level);
    assign w_flip    = i_tick && w_differs &&
                       (((r_state == DB_STABLE)  && SINGLE_SAMPLE) ||
                        ((r_state == DB_PENDING) && (r_cnt == CNT_LAST)));

    // Filter FSM with its stability counter and level register, advanced
    // only on sample ticks.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= DB_STABLE;
            r_cnt   <= '0;
            r_level <= RESET_LEVEL;
        end else if (i_tick) begin
            case (r_state)
                DB_STABLE: begin
                    if (w_differs && !SINGLE_SAMPLE) begin
                        r_cnt   <= CNT_ONE;
                        r_state <= DB_PENDING;
                    end else begin
                        r_cnt <= '0;
                    end
                end
                DB_PENDING: begin
                    if (!w_differs || (r_cnt == CNT_LAST)) begin
                        // Either the bounce died out or the new level held
                        // long enough; both end the pending run.
                        r_cnt   <= '0;
                        r_state <= DB_STABLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                default: begin
                    r_cnt   <= '0;
                    r_state <= DB_STABLE;
                end
            endcase
            if (w_flip) begin
                r_level <= ~r_level;
            end
        end
    end

    assign o_level = r_level;

`ifdef INPUT_DEBOUNCER_EDGE_EN
    logic r_rise;
    logic r_fall;

    // Edge flops load on the same edge as the level so a pulse lines up
    // with the cycle the level changes and lasts exactly one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_rise <= w_flip && !r_level;
            r_fall <= w_flip &&  r_level;
        end
    end

    assign o_rise = r_rise;
    assign o_fall = r_fall;
`else
    assign o_rise = 1'b0;
    assign o_fall = 1'b0;
`endif

endmodule : debounce_channel

// File: rtl/input_debouncer.sv
// ---------------------------------------------------------------------------
// input_debouncer
// Multi-channel push-button debouncer. One shared prescaler produces the
// sample tick; each channel is an independent debounce_channel lane.
// Optional feature macro: INPUT_DEBOUNCER_EDGE_EN (enables rise/fall pulses;
// when undefined both pulse outputs are constant 0).
// ---------------------------------------------------------------------------
module input_debouncer
    import input_debouncer_pkg::*;
#(
    parameter int                      NUM_CHANNELS   = 5,
    parameter int                      SAMPLE_PERIOD  = 100000,
    parameter int                      STABLE_SAMPLES = 8,
    parameter logic [NUM_CHANNELS-1:0] RESET_VALUE    = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CHANNELS-1:0] raw_in,
    output logic [NUM_CHANNELS-1:0] debounced_out,
    output logic [NUM_CHANNELS-1:0] rise_pulse,
    output logic [NUM_CHANNELS-1:0] fall_pulse
);

    localparam int PW = presc_width(SAMPLE_PERIOD);
    localparam logic [PW-1:0] PRESC_LAST = PW'(SAMPLE_PERIOD - 1);
    localparam logic [PW-1:0] PRESC_ONE  = PW'(1);

    logic [PW-1:0] r_presc;
    logic          w_tick;

    // Tick is high for the whole cycle in which the prescaler sits at its
    // last count, so the first tick lands SAMPLE_PERIOD cycles after reset.
    assign w_tick = (r_presc == PRESC_LAST);

    // Shared sample prescaler wrapping 0..SAMPLE_PERIOD-1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + PRESC_ONE;
        end
    end

    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_chan
        debounce_channel #(
            .STABLE_SAMPLES (STABLE_SAMPLES),
            .RESET_LEVEL    (RESET_VALUE[g])
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .i_tick  (w_tick),
            .i_raw   (raw_in[g]),
            .o_level (debounced_out[g]),
            .o_rise  (rise_pulse[g]),
            .o_fall  (fall_pulse[g])
        );
    end

endmodule : input_debouncer
